// File: rtl/mem_access_unit.sv
// Data-memory access unit: runs one req/ack bus transaction per load/store,
// producing byte enables, lane-replicated store data and extended load data.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        rw_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  lo_q;
    logic [2:0]  type_q;
    logic        req_s;

    // Legality of a request; only meaningful when at least one of rd/wr is set.
    function automatic logic access_ok(input logic rd, input logic wr,
                                       input logic [2:0] t, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else begin
            case (t)
                3'b000:  ok = 1'b1;
                3'b001:  ok = ~a[0];
                3'b010:  ok = (a == 2'b00);
                3'b100:  ok = rd;
                3'b101:  ok = rd & ~a[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
        logic [3:0] be;
        case (t[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] r;
        case (t[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] t, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        logic [31:0] r;
        sb = w >> {a, 3'b000};
        sh = w >> {a[1], 4'b0000};
        case (t)
            3'b000:  r = {{24{sb[7]}}, sb[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = w;
            3'b100:  r = {24'h000000, sb[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign req_s = mem_read | mem_write;

    // Upstream hold: asserted in the accepting IDLE cycle and throughout REQ.
    always_comb begin
        stall = 1'b0;
        if (state_q == S_REQ) begin
            stall = 1'b1;
        end else if (state_q == S_IDLE) begin
            stall = req_s;
        end else begin
            stall = 1'b0;
        end
    end

    // Transaction FSM with all bus and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            lo_q     <= 2'b00;
            type_q   <= 3'b000;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= 4'b0000;
            dm_wdata <= 32'h0000_0000;
            done     <= 1'b0;
            fault    <= 1'b0;
            rdata    <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (req_s) begin
                        type_q   <= rw_type;
                        lo_q     <= addr[1:0];
                        cnt_q    <= 8'd0;
                        dm_we    <= mem_write;
                        dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        dm_be    <= byte_en(rw_type, addr[1:0]);
                        dm_wdata <= store_lanes(rw_type, wdata);
                        if (access_ok(mem_read, mem_write, rw_type, addr[1:0])) begin
                            state_q <= S_REQ;
                            dm_req  <= 1'b1;
                        end else begin
                            state_q <= S_FAULT;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                            rdata   <= 32'h0000_0000;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (dm_ack) begin
                        state_q <= S_DONE;
                        dm_req  <= 1'b0;
                        done    <= 1'b1;
                        rdata   <= dm_we ? 32'h0000_0000 : load_extract(type_q, lo_q, dm_rdata);
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_FAULT;
                        dm_req  <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        rdata   <= 32'h0000_0000;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE, S_FAULT: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    dm_req  <= 1'b0;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle comparison against a
// transaction-level model of expected bus/handshake behaviour.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  rw_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int checks;
    int failures;

    logic        chk_en;
    logic        exp_stall;
    logic        exp_req;
    logic        exp_done;
    logic        exp_fault;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;

    mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .rw_type(rw_type), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .fault(fault), .rdata(rdata), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_legal(input logic rd, input logic wr, input logic [2:0] t,
                                     input logic [31:0] a);
        logic typeok;
        if (rd && wr) return 1'b0;
        if (rd) typeok = t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else    typeok = t inside {3'b000, 3'b001, 3'b010};
        if (!typeok) return 1'b0;
        return (int'(a % 32'd4) % m_size(t)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        logic [3:0] b;
        int base;
        b = 4'b0000;
        base = int'(a % 32'd4);
        for (int k = 0; k < m_size(t); k++) b[base + k] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = m_size(t);
        r = 32'h0;
        if (n == 0) return r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n = m_size(t);
        if (n == 4) return w;
        if (n == 0) return 32'h0;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = (w >> (8 * int'(a % 32'd4))) & mask;
        if (t[2] == 1'b0 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Per-cycle comparison of DUT outputs against the current expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'h0, stall}, {31'h0, exp_stall});
            chk("dm_req", {31'h0, dm_req}, {31'h0, exp_req});
            chk("done", {31'h0, done}, {31'h0, exp_done});
            chk("fault", {31'h0, fault}, {31'h0, exp_fault});
            chk("rdata", rdata, exp_rdata);
            if (exp_req) begin
                chk("dm_we", {31'h0, dm_we}, {31'h0, exp_we});
                chk("dm_addr", dm_addr, exp_addr);
                chk("dm_be", {28'h0, dm_be}, {28'h0, exp_be});
                chk("dm_wdata", dm_wdata, exp_wdata);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ack_at: REQ-cycle index (0 = first dm_req cycle) that sees dm_ack; -1 never.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int ack_at);
        logic ok;
        logic acked;
        logic flt;
        ok = m_legal(rd, wr, t, a);
        acked = 1'b0;
        mem_read = rd; mem_write = wr; rw_type = t; addr = a; wdata = wd; dm_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_fault = 1'b0;
        tick();
        if (ok) begin
            for (int i = 0; i < TO && !acked; i++) begin
                exp_stall = 1'b1; exp_req = 1'b1; exp_we = wr;
                exp_addr = {a[31:2], 2'b00};
                exp_be = m_be(t, a);
                exp_wdata = m_wdata(t, wd);
                dm_ack = (i == ack_at);
                dm_rdata = dm_ack ? rw : 32'hDEAD_BEEF;
                acked = dm_ack;
                tick();
            end
            dm_ack = 1'b0;
        end
        flt = !ok || !acked;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1; exp_fault = flt;
        exp_rdata = (flt || wr) ? 32'h0 : m_load(t, a, rw);
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        exp_done = 1'b0; exp_fault = 1'b0;
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; rw_type = 3'b000;
        addr = 32'h0; wdata = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_fault = 1'b0;
        exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;

        #12;
        chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_be", {28'h0, dm_be}, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;

        chk("pin_lb", m_load(3'b000, 32'h1003, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("pin_lhu", m_load(3'b101, 32'h2002, 32'h9ABC_0000), 32'h0000_9ABC);
        chk("pin_lh", m_load(3'b001, 32'h2002, 32'h9ABC_0000), 32'hFFFF_9ABC);
        chk("pin_be_lb", {28'h0, m_be(3'b000, 32'h1003)}, 32'h8);
        chk("pin_be_sb", {28'h0, m_be(3'b000, 32'h0101)}, 32'h2);
        chk("pin_be_lh", {28'h0, m_be(3'b101, 32'h2002)}, 32'hC);
        chk("pin_wd_sb", m_wdata(3'b000, 32'h0000_00A5), 32'hA5A5_A5A5);
        chk("pin_legal_sw", {31'h0, m_legal(1'b0, 1'b1, 3'b010, 32'h0102)}, 32'h0);

        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        chk("lit_lb", rdata, 32'hFFFF_FF80);
        run_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 0);
        chk("lit_lhu", rdata, 32'h0000_9ABC);
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 2);
        chk("lit_lh", rdata, 32'hFFFF_9ABC);
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0);
        chk("lit_sb_rdata", rdata, 32'h0);
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 32'h0, 0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h5555_AAAA, -1);
        run_txn(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, 3'b011, 32'h0000_0600, 32'h0, 32'h0, 0);
        run_txn(1'b0, 1'b1, 3'b100, 32'h0000_0600, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_0601, 32'h0, 32'h0, 0);
        run_txn(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 32'h0, 1);
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0010, 32'h0, 32'h0000_00F0, 0);
        chk("lit_lbu", rdata, 32'h0000_00F0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, TO - 1);
        chk("lit_lw_lastack", rdata, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of a REQ phase.
        mem_read = 1'b1; rw_type = 3'b010; addr = 32'h0000_0040;
        exp_stall = 1'b1; exp_req = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0040;
            exp_be = 4'hF; exp_wdata = m_wdata(3'b010, wdata);
            tick();
        end
        rst_n = 1'b0; mem_read = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_fault = 1'b0; exp_rdata = 32'h0;
        #1;
        chk("arst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("arst_stall", {31'h0, stall}, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        tick();
        rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
        tick();
        tick();
        dm_ack = 1'b0;
        tick();
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h1234_5678, 0);
        chk("lit_lw_after_rst", rdata, 32'h1234_5678);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
